// File: rtl/mem_check.sv
// -----------------------------------------------------------------------------
// mem_check
//
// Read-back verifier for the on-chip RAM after initialisation. Once started it
// sweeps addresses 0..ADDR_MAX through the RAM read port and checks that every
// word equals its own address. Results: sticky finish, pass, mismatch count,
// and the address and data of the first mismatch.
//
// The write side of the port is tied off (wren=0, data=0) so this block can
// never disturb the RAM contents it is checking.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   address        out  RAM read address (issue counter)
//   data           out  RAM write data, constant 0
//   wren           out  RAM write enable, constant 0
//   q              in   RAM read data, valid READ_LATENCY cycles after address
//   start          in   level; only looked at while idle
//   finish         out  sweep complete; sticky until reset
//   pass           out  finish && err_count == 0 (combinational)
//   err_count      out  number of mismatching words (DATA_WIDTH+1 bits)
//   first_err_addr out  address of first mismatch, 0 if none
//   first_err_data out  q at first mismatch, 0 if none
//   dbg_state      out  FSM state: 0=IDLE 1=READ 2=DRAIN 3=DONE
//
// Start/finish protocol: start is a level sampled only in IDLE; a single edge
// with start=1 launches exactly one sweep. finish then rises and stays high
// until reset, and start is ignored from then on.
// -----------------------------------------------------------------------------
module mem_check #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_MAX     = 255,  // must be <= 2**DATA_WIDTH-1
    parameter int READ_LATENCY = 1     // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  wren,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic                  start,
    output logic                  finish,
    output logic                  pass,
    output logic [DATA_WIDTH:0]   err_count,
    output logic [DATA_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR  = DATA_WIDTH'(ADDR_MAX);
    localparam logic [2:0]            DRAIN_INIT = 3'(READ_LATENCY - 1);

    state_t                state;
    logic [2:0]            drain_cnt;

    // Read-tag pipeline: one entry per cycle, tracking which address the
    // word currently on q belongs to. The last stage lines up with q.
    logic                  tag_valid [READ_LATENCY];
    logic [DATA_WIDTH-1:0] tag_addr  [READ_LATENCY];

    logic                  cmp_valid;
    logic                  mismatch;

    assign cmp_valid = tag_valid[READ_LATENCY-1];
    assign mismatch  = cmp_valid && (q != tag_addr[READ_LATENCY-1]);

    assign data      = '0;
    assign wren      = 1'b0;
    assign pass      = finish && (err_count == '0);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            address        <= '0;
            finish         <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_addr[i]  <= '0;
            end
        end else begin
            // A tag is valid only for cycles in which a real read is issued.
            tag_valid[0] <= (state == READ);
            tag_addr[0]  <= address;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_addr[i]  <= tag_addr[i-1];
            end

            if (mismatch) begin
                err_count <= err_count + 1'b1;
                // Only the very first mismatch is recorded.
                if (err_count == '0) begin
                    first_err_addr <= tag_addr[READ_LATENCY-1];
                    first_err_data <= q;
                end
            end

            case (state)
                IDLE: begin
                    address <= '0;
                    if (start) begin
                        state <= READ;
                    end
                end
                READ: begin
                    // Stop at LAST_ADDR rather than wrapping, so a full
                    // 2**DATA_WIDTH sweep never rolls back to 0.
                    if (address == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end else begin
                        address <= address + 1'b1;
                    end
                end
                DRAIN: begin
                    // Spend READ_LATENCY cycles here so the last read
                    // has been compared before DONE.
                    if (drain_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_check.sv
// -----------------------------------------------------------------------------
// tb_mem_check
//
// Two instances: dut a uses the defaults (ADDR_MAX=255, READ_LATENCY=1),
// dut b uses ADDR_MAX=15, READ_LATENCY=2. Each sits on its own RAM model.
// A reference model derives every output from the edge count since the
// start edge and the memory contents; a single compare process checks both
// DUTs on every falling edge. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_check;

    localparam int A_MAX = 255;
    localparam int A_LAT = 1;
    localparam int B_MAX = 15;
    localparam int B_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_v [2];
    logic       start_v [2];
    logic [7:0] q_v     [2];
    logic [7:0] addr_v  [2];
    logic [7:0] data_v  [2];
    logic       wren_v  [2];
    logic       fin_v   [2];
    logic       pass_v  [2];
    logic [8:0] errc_v  [2];
    logic [7:0] fea_v   [2];
    logic [7:0] fed_v   [2];
    logic [1:0] st_v    [2];

    mem_check #(.DATA_WIDTH(8), .ADDR_MAX(A_MAX), .READ_LATENCY(A_LAT)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n_v[0]),
        .address        (addr_v[0]),
        .data           (data_v[0]),
        .wren           (wren_v[0]),
        .q              (q_v[0]),
        .start          (start_v[0]),
        .finish         (fin_v[0]),
        .pass           (pass_v[0]),
        .err_count      (errc_v[0]),
        .first_err_addr (fea_v[0]),
        .first_err_data (fed_v[0]),
        .dbg_state      (st_v[0])
    );

    mem_check #(.DATA_WIDTH(8), .ADDR_MAX(B_MAX), .READ_LATENCY(B_LAT)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_v[1]),
        .address        (addr_v[1]),
        .data           (data_v[1]),
        .wren           (wren_v[1]),
        .q              (q_v[1]),
        .start          (start_v[1]),
        .finish         (fin_v[1]),
        .pass           (pass_v[1]),
        .err_count      (errc_v[1]),
        .first_err_addr (fea_v[1]),
        .first_err_data (fed_v[1]),
        .dbg_state      (st_v[1])
    );

    // ---------------- RAM models ----------------
    logic [7:0] mem [2][256];
    logic [7:0] q1_b;

    always @(posedge clk) begin
        q_v[0] <= mem[0][addr_v[0]];
        q1_b   <= mem[1][addr_v[1]];
        q_v[1] <= q1_b;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // trk: a sweep has been launched since the last reset.
    // kk:  number of rising edges since the start edge (start edge = 0).
    bit trk [2];
    int kk  [2];
    int max_addr_b = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n_v[i]) begin
                trk[i] <= 1'b0;
                kk[i]  <= 0;
            end else if (!trk[i] && start_v[i]) begin
                trk[i] <= 1'b1;
                kk[i]  <= 0;
            end else if (trk[i]) begin
                kk[i] <= kk[i] + 1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int    am;
            int    rl;
            int    e_addr;
            int    e_cnt;
            int    e_fa;
            int    e_fd;
            int    e_st;
            bit    e_fin;
            string p;
            am     = (i == 0) ? A_MAX : B_MAX;
            rl     = (i == 0) ? A_LAT : B_LAT;
            p      = (i == 0) ? "a" : "b";
            e_cnt  = 0;
            e_fa   = 0;
            e_fd   = 0;
            e_addr = 0;
            e_fin  = 1'b0;
            e_st   = 0;
            if (trk[i]) begin
                // Address A appears after edge A and is compared after edge A+1+rl.
                e_addr = (kk[i] < am) ? kk[i] : am;
                e_fin  = (kk[i] >= am + rl + 2);
                if (kk[i] <= am)           e_st = 1;
                else if (kk[i] <= am + rl) e_st = 2;
                else                       e_st = 3;
                for (int a = 0; a <= am; a++) begin
                    if (int'(mem[i][a]) != a && (a + 1 + rl) <= kk[i]) begin
                        if (e_cnt == 0) begin
                            e_fa = a;
                            e_fd = int'(mem[i][a]);
                        end
                        e_cnt++;
                    end
                end
                if (i == 1 && int'(addr_v[1]) > max_addr_b) max_addr_b = int'(addr_v[1]);
            end
            check({p, ".address"},        addr_v[i], e_addr);
            check({p, ".finish"},         fin_v[i],  e_fin);
            check({p, ".pass"},           pass_v[i], e_fin && (e_cnt == 0));
            check({p, ".err_count"},      errc_v[i], e_cnt);
            check({p, ".first_err_addr"}, fea_v[i],  e_fa);
            check({p, ".first_err_data"}, fed_v[i],  e_fd);
            check({p, ".state"},          st_v[i],   e_st);
            check({p, ".wren"},           wren_v[i], 0);
            check({p, ".data"},           data_v[i], 0);
        end
    end

    // ---------------- driver tasks ----------------
    // pat: 0 identity, 1 S[5]=AA, 2 S[3]=0 S[200]=7 S[255]=0, 3 all zero
    task automatic load(input int id, input int pat);
        for (int a = 0; a < 256; a++) mem[id][a] = (pat == 3) ? 8'h00 : 8'(a);
        if (pat == 1) mem[id][5] = 8'hAA;
        if (pat == 2) begin
            mem[id][3]   = 8'h00;
            mem[id][200] = 8'h07;
            mem[id][255] = 8'h00;
        end
    endtask

    // Reset, load the pattern while in reset, pulse start; edge 0 is the
    // edge that samples start=1.
    task automatic launch(input int id, input int pat);
        @(negedge clk);
        rst_n_v[id] = 1'b0;
        start_v[id] = 1'b0;
        @(posedge clk);
        #1;
        load(id, pat);
        @(negedge clk);
        rst_n_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
    endtask

    // Returns the number of edges after the start edge until finish is seen.
    task automatic run_sweep(input int id, input int pat, output int lat);
        launch(id, pat);
        lat = 0;
        while (!fin_v[id] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("sweep_finish_within_bound", fin_v[id], 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        int n;
        rst_n_v[0] = 1'b0;
        rst_n_v[1] = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        load(0, 0);
        load(1, 0);
        repeat (3) @(negedge clk);
        check("a.reset_address", addr_v[0], 0);
        check("a.reset_finish",  fin_v[0],  0);

        // identity memory
        run_sweep(0, 0, lat);
        check("t1.latency",        lat,       258);
        check("t1.pass",           pass_v[0], 1);
        check("t1.err_count",      errc_v[0], 0);
        check("t1.first_err_addr", fea_v[0],  0);
        check("t1.first_err_data", fed_v[0],  0);

        // single corrupted word
        run_sweep(0, 1, lat);
        check("t2.finish",         fin_v[0],  1);
        check("t2.pass",           pass_v[0], 0);
        check("t2.err_count",      errc_v[0], 1);
        check("t2.first_err_addr", fea_v[0],  8'h05);
        check("t2.first_err_data", fed_v[0],  8'hAA);

        // three corrupted words including the last address
        run_sweep(0, 2, lat);
        check("t3.err_count",      errc_v[0], 3);
        check("t3.first_err_addr", fea_v[0],  3);
        check("t3.first_err_data", fed_v[0],  0);

        // all-zero memory
        run_sweep(0, 3, lat);
        check("t4.err_count",      errc_v[0], 255);
        check("t4.pass",           pass_v[0], 0);
        check("t4.first_err_addr", fea_v[0],  1);
        check("t4.first_err_data", fed_v[0],  0);

        // reset mid-sweep at address 100 (error already recorded at 5)
        launch(0, 1);
        n = 0;
        while (addr_v[0] != 8'd100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5.reached_addr_100", addr_v[0], 100);
        check("t5.err_before_reset", errc_v[0], 1);
        rst_n_v[0] = 1'b0;
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        check("t5.address",        addr_v[0], 0);
        check("t5.err_count",      errc_v[0], 0);
        check("t5.finish",         fin_v[0],  0);
        check("t5.pass",           pass_v[0], 0);
        check("t5.first_err_addr", fea_v[0],  0);
        check("t5.first_err_data", fed_v[0],  0);
        check("t5.state_idle",     st_v[0],   0);

        // restart gives the full correct result
        run_sweep(0, 0, lat);
        check("t5.restart_latency", lat,       258);
        check("t5.restart_pass",    pass_v[0], 1);

        // start held high in DONE must not re-sweep
        start_v[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("t6.finish",  fin_v[0],  1);
        check("t6.address", addr_v[0], 255);
        check("t6.state",   st_v[0],   3);
        start_v[0] = 1'b0;

        // small sweep with two-cycle read latency
        max_addr_b = 0;
        run_sweep(1, 0, lat);
        check("b.latency",  lat,        19);
        check("b.pass",     pass_v[1],  1);
        check("b.max_addr", max_addr_b, 15);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
